peak_level_meter: RTL and testbench

//  Consumes signed PCM samples from the I2S deserializer plus a one-cycle sample strobe.

---
 rtl/audio_meter_pkg.sv | 33 +++
 rtl/abs_sat_reg.sv | 46 ++++
 rtl/peak_level_meter.sv | 148 ++++++++++++++
 tb/tb_peak_level_meter.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_meter_pkg.sv
// Shared types and helpers for the audio peak level meter.
//   meter_state_t : envelope follower state (IDLE / HOLD / DECAY)
//   abs_sat       : saturating magnitude of a sign-extended PCM sample
//   bar_on        : one thermometer segment decision for a given envelope
package audio_meter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        DECAY = 2'd2
    } meter_state_t;

    localparam int unsigned MAX_W = 32;

    // |sample| for an n-bit sample held sign-extended in MAX_W bits; full-scale negative saturates.
    function automatic logic [MAX_W-1:0] abs_sat(input logic [MAX_W-1:0] sample,
                                                 input int unsigned      n);
        logic [MAX_W-1:0] max_mag;
        logic [MAX_W-1:0] mag;
        max_mag = (MAX_W'(1) << (n - 1)) - MAX_W'(1);
        mag     = sample[MAX_W-1] ? (~sample + MAX_W'(1)) : sample;
        abs_sat = (mag > max_mag) ? max_mag : mag;
    endfunction

    // Segment idx lights once the envelope reaches 2**(n-1-leds+idx): 6 dB per segment.
    function automatic logic bar_on(input logic [MAX_W-1:0] env,
                                    input int unsigned      n,
                                    input int unsigned      leds,
                                    input int unsigned      idx);
        bar_on = (env >= (MAX_W'(1) << (n - 1 - leds + idx)));
    endfunction

endpackage

// File: rtl/abs_sat_reg.sv
// First pipeline stage: registered saturating magnitude and full-scale detect.
//   clk, rst_n   : AUD_BCLK clock, async active-low reset
//   valid        : new sample strobe
//   freeze       : suppresses capture and drops the staged sample
//   sample_data  : signed PCM sample
//   s1_valid     : mag/is_clip hold a fresh sample
//   mag          : saturated magnitude (N-1 bits)
//   is_clip      : sample was positive or negative full scale
module abs_sat_reg
    import audio_meter_pkg::*;
#(
    parameter int unsigned N = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         valid,
    input  logic         freeze,
    input  logic [N-1:0] sample_data,
    output logic         s1_valid,
    output logic [N-2:0] mag,
    output logic         is_clip
);

    localparam int unsigned M = N - 1;
    localparam logic [N-1:0] POS_FS = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] NEG_FS = {1'b1, {(N-1){1'b0}}};

    logic capture_c;
    assign capture_c = valid && !freeze;

    // Capture magnitude; a sample staged here is dropped if freeze rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            mag      <= '0;
            is_clip  <= 1'b0;
        end else begin
            s1_valid <= capture_c;
            if (capture_c) begin
                mag     <= M'(abs_sat(MAX_W'(signed'(sample_data)), N));
                is_clip <= (sample_data == POS_FS) || (sample_data == NEG_FS);
            end
        end
    end

endmodule

// File: rtl/peak_level_meter.sv
// Peak envelope meter: instant attack, hold, exponential decay, log LED bar, sticky clip.
//   clk, rst_n   : AUD_BCLK clock, async active-low reset
//   valid        : one-cycle strobe, sample_data is new
//   sample_data  : signed PCM sample
//   freeze       : ignore valid, discard in-flight samples, hold outputs
//   level        : envelope magnitude
//   bar          : thermometer LED bar, 6 dB per segment
//   clip         : sticky clip indicator
//   level_valid  : one-cycle pulse when level/bar/clip update (3 cycles after valid)
module peak_level_meter
    import audio_meter_pkg::*;
#(
    parameter int unsigned N            = 16,
    parameter int unsigned LEDS         = 15,
    parameter int unsigned HOLD_SAMPLES = 4800,
    parameter int unsigned DECAY_SHIFT  = 6,
    parameter int unsigned CLIP_HOLD    = 24000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            valid,
    input  logic [N-1:0]    sample_data,
    input  logic            freeze,
    output logic [N-2:0]    level,
    output logic [LEDS-1:0] bar,
    output logic            clip,
    output logic            level_valid
);

    localparam int unsigned M      = N - 1;
    localparam int unsigned HOLD_W = (HOLD_SAMPLES > 0) ? $clog2(HOLD_SAMPLES + 1) : 1;
    localparam int unsigned CLIP_W = (CLIP_HOLD > 0) ? $clog2(CLIP_HOLD + 1) : 1;

    logic              s1_valid;
    logic [M-1:0]      mag;
    logic              is_clip;

    meter_state_t      state;
    logic [M-1:0]      env;
    logic [HOLD_W-1:0] hold_cnt;
    logic [CLIP_W-1:0] clip_cnt;
    logic              clip_flag;
    logic              s2_valid;

    logic [M-1:0]      decay_step_c;
    logic [LEDS-1:0]   bar_c;

    abs_sat_reg #(.N(N)) u_abs_sat_reg (
        .clk         (clk),
        .rst_n       (rst_n),
        .valid       (valid),
        .freeze      (freeze),
        .sample_data (sample_data),
        .s1_valid    (s1_valid),
        .mag         (mag),
        .is_clip     (is_clip)
    );

    // Decay amount never drops below 1 so the envelope always reaches zero.
    always_comb begin
        decay_step_c = env >> DECAY_SHIFT;
        if (decay_step_c == '0) begin
            decay_step_c = M'(1);
        end
    end

    // Thermometer encoding of the current envelope.
    always_comb begin
        bar_c = '0;
        for (int unsigned i = 0; i < LEDS; i++) begin
            bar_c[i] = bar_on(MAX_W'(env), N, LEDS, i);
        end
    end

    // Stage 2: envelope FSM and clip hold counter, advanced once per sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            env       <= '0;
            hold_cnt  <= '0;
            clip_cnt  <= '0;
            clip_flag <= 1'b0;
            s2_valid  <= 1'b0;
        end else begin
            s2_valid <= 1'b0;
            if (s1_valid && !freeze) begin
                s2_valid <= 1'b1;
                if ((mag >= env) && (mag != '0)) begin
                    env      <= mag;
                    hold_cnt <= HOLD_W'(HOLD_SAMPLES);
                    state    <= HOLD;
                end else begin
                    case (state)
                        HOLD: begin
                            if (hold_cnt != '0) begin
                                hold_cnt <= hold_cnt - HOLD_W'(1);
                            end else begin
                                state <= DECAY;
                            end
                        end
                        DECAY: begin
                            if (env <= decay_step_c) begin
                                env   <= '0;
                                state <= IDLE;
                            end else begin
                                env <= env - decay_step_c;
                            end
                        end
                        IDLE:    ;
                        default: state <= IDLE;
                    endcase
                end

                if (is_clip) begin
                    clip_cnt  <= CLIP_W'(CLIP_HOLD);
                    clip_flag <= 1'b1;
                end else begin
                    if (clip_cnt != '0) begin
                        clip_cnt <= clip_cnt - CLIP_W'(1);
                    end
                    // Clears on the sample that takes the counter to zero.
                    if (clip_cnt <= CLIP_W'(1)) begin
                        clip_flag <= 1'b0;
                    end
                end
            end
        end
    end

    // Stage 3: publish envelope, bar and clip together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level       <= '0;
            bar         <= '0;
            clip        <= 1'b0;
            level_valid <= 1'b0;
        end else begin
            level_valid <= 1'b0;
            if (s2_valid && !freeze) begin
                level       <= env;
                bar         <= bar_c;
                clip        <= clip_flag;
                level_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_peak_level_meter.sv
// Self-checking bench for peak_level_meter against a sample-count based reference model.
module tb_peak_level_meter;

    localparam int unsigned N            = 16;
    localparam int unsigned LEDS         = 15;
    localparam int unsigned HOLD_SAMPLES = 4;
    localparam int unsigned DECAY_SHIFT  = 2;
    localparam int unsigned CLIP_HOLD    = 3;
    localparam int          FAR          = 1 << 20;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            valid;
    logic [N-1:0]    sample_data;
    logic            freeze;
    logic [N-2:0]    level;
    logic [LEDS-1:0] bar;
    logic            clip;
    logic            level_valid;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    peak_level_meter #(
        .N(N), .LEDS(LEDS), .HOLD_SAMPLES(HOLD_SAMPLES),
        .DECAY_SHIFT(DECAY_SHIFT), .CLIP_HOLD(CLIP_HOLD)
    ) dut (
        .clk(clk), .rst_n(rst_n), .valid(valid), .sample_data(sample_data),
        .freeze(freeze), .level(level), .bar(bar), .clip(clip), .level_valid(level_valid)
    );

    // Reference model: envelope plus samples elapsed since the last peak / last clip.
    int m_env;
    int m_since_peak;
    int m_since_clip;

    function automatic void model_reset();
        m_env        = 0;
        m_since_peak = FAR;
        m_since_clip = FAR;
    endfunction

    function automatic void model_step(input logic [N-1:0] s, output logic [N-2:0] e_level,
                                       output logic [LEDS-1:0] e_bar, output logic e_clip);
        int v, mag, step;
        v   = int'(signed'(s));
        mag = (v < 0) ? -v : v;
        if (mag > (1 << (N - 1)) - 1) mag = (1 << (N - 1)) - 1;
        if (mag >= m_env && mag != 0) begin
            m_env        = mag;
            m_since_peak = 0;
        end else begin
            if (m_since_peak < FAR) m_since_peak++;
            // Peak sample, HOLD_SAMPLES held samples, one transition sample, then decay.
            if (m_since_peak > int'(HOLD_SAMPLES) + 1) begin
                step  = m_env >> DECAY_SHIFT;
                if (step < 1) step = 1;
                m_env = (m_env > step) ? m_env - step : 0;
            end
        end
        if (v == (1 << (N - 1)) - 1 || v == -(1 << (N - 1))) m_since_clip = 0;
        else if (m_since_clip < FAR) m_since_clip++;
        e_clip  = (m_since_clip == 0) || (m_since_clip < int'(CLIP_HOLD));
        e_level = (N - 1)'(m_env);
        for (int i = 0; i < int'(LEDS); i++) e_bar[i] = (m_env >= (1 << (int'(N) - 1 - int'(LEDS) + i)));
    endfunction

    // Drive one sample and wait (bounded) for its result; returns what the DUT showed.
    task automatic send(input logic [N-1:0] s, output logic got, output int lat,
                        output logic [N-2:0] o_level, output logic [LEDS-1:0] o_bar, output logic o_clip);
        @(negedge clk);
        sample_data = s;
        valid       = 1'b1;
        @(negedge clk);
        valid       = 1'b0;
        sample_data = N'($urandom);
        got = 1'b0;
        lat = 1;
        while (!got && lat <= 8) begin
            if (level_valid) got = 1'b1;
            else begin
                @(negedge clk);
                lat++;
            end
        end
        o_level = level;
        o_bar   = bar;
        o_clip  = clip;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    // Sends one sample and compares latency and outputs with the model.
    task automatic run_sample(input logic [N-1:0] s, input string name, output logic [N-2:0] o_level,
                              output logic [LEDS-1:0] o_bar);
        logic got, o_clip, e_clip;
        int lat;
        logic [N-2:0] e_level;
        logic [LEDS-1:0] e_bar;
        model_step(s, e_level, e_bar, e_clip);
        send(s, got, lat, o_level, o_bar, o_clip);
        checks++;
        if (!got || lat !== 3) $display("FAIL %s latency: got=%0b lat=%0d, required lat=3", name, got, lat);
        else passed++;
        checks++;
        if ({o_level, o_bar, o_clip} !== {e_level, e_bar, e_clip})
            $display("FAIL %s sample=%h: level=%0d bar=%h clip=%b, required level=%0d bar=%h clip=%b",
                     name, s, o_level, o_bar, o_clip, e_level, e_bar, e_clip);
        else passed++;
    endtask

    task automatic test_reset();
        logic [N-2:0] l;
        logic [LEDS-1:0] b;
        rst_n = 1'b0; valid = 1'b0; freeze = 1'b0; sample_data = '0;
        model_reset();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            valid       = ~valid;
            sample_data = N'($urandom);
        end
        @(negedge clk);
        valid = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if ({level, bar, clip, level_valid} !== '0)
            $display("FAIL reset_outputs: level=%0d bar=%h clip=%b lv=%b, required all 0", level, bar, clip, level_valid);
        else passed++;
        rst_n = 1'b1;
        run_sample('0, "reset_zero", l, b);
        @(negedge clk);
        checks++;
        if (level_valid !== 1'b0) $display("FAIL lv_pulse_width: level_valid=%b, required 0", level_valid);
        else passed++;
    endtask

    task automatic test_clip();
        logic [N-2:0] l;
        logic [LEDS-1:0] b;
        run_sample(16'h8000, "clip_neg_fs", l, b);
        checks++;
        if (l !== 15'd32767 || b !== 15'h7FFF || clip !== 1'b1)
            $display("FAIL clip_fullscale: level=%0d bar=%h clip=%b, required 32767 7fff 1", l, b, clip);
        else passed++;
        for (int i = 0; i < 3; i++) run_sample('0, "clip_tail", l, b);
        checks++;
        if (clip !== 1'b0) $display("FAIL clip_release: clip=%b, required 0", clip);
        else passed++;
    endtask

    task automatic test_decay();
        logic [N-2:0] l;
        logic [LEDS-1:0] b;
        int exp_seq [9] = '{1000, 1000, 1000, 1000, 1000, 1000, 750, 563, 423};
        int n;
        do_reset();
        run_sample(16'd1000, "decay_peak", l, b);
        for (int i = 1; i < 9; i++) begin
            run_sample('0, "decay_seq", l, b);
            checks++;
            if (int'(l) !== exp_seq[i]) $display("FAIL decay_curve[%0d]: level=%0d, required %0d", i, l, exp_seq[i]);
            else passed++;
        end
        n = 0;
        while (m_env != 0 && n < 60) begin
            run_sample('0, "decay_tail", l, b);
            n++;
        end
        run_sample('0, "decay_idle", l, b);
        checks++;
        if (l !== '0 || b !== '0) $display("FAIL decay_to_zero: level=%0d bar=%h, required 0 0", l, b);
        else passed++;
    endtask

    task automatic test_bar();
        logic [N-2:0] l;
        logic [LEDS-1:0] b;
        do_reset();
        run_sample(16'd256, "bar_pos", l, b);
        checks++;
        if (b !== 15'h01FF) $display("FAIL bar_256: bar=%h, required 01ff", b);
        else passed++;
        run_sample(16'hFF00, "bar_neg", l, b);
        checks++;
        if (l !== 15'd256 || b !== 15'h01FF) $display("FAIL bar_minus256: level=%0d bar=%h, required 256 01ff", l, b);
        else passed++;
        run_sample(16'd200, "bar_below", l, b);
        checks++;
        if (l !== 15'd256) $display("FAIL hold_below_env: level=%0d, required 256", l);
        else passed++;
    endtask

    task automatic test_freeze();
        logic [N-2:0] l0, l;
        logic [LEDS-1:0] b0, b;
        logic c0;
        int pulses;
        l0 = level; b0 = bar; c0 = clip;
        pulses = 0;
        @(negedge clk);
        freeze = 1'b1; valid = 1'b1; sample_data = 16'd20000;
        @(negedge clk);
        valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (level_valid) pulses++;
            @(negedge clk);
        end
        freeze = 1'b0;
        // A sample already staged when freeze rises must be discarded.
        valid = 1'b1; sample_data = 16'd20000;
        @(negedge clk);
        valid  = 1'b0;
        freeze = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (level_valid) pulses++;
            @(negedge clk);
        end
        checks++;
        if (pulses !== 0 || level !== l0 || bar !== b0 || clip !== c0)
            $display("FAIL freeze_hold: pulses=%0d level=%0d bar=%h clip=%b, required 0 %0d %h %b",
                     pulses, level, bar, clip, l0, b0, c0);
        else passed++;
        freeze = 1'b0;
        run_sample(16'd20000, "freeze_resume", l, b);
    endtask

    task automatic test_back_to_back();
        logic [N-2:0] e_level [3];
        logic [LEDS-1:0] e_bar [3];
        logic e_clip [3];
        logic [N-1:0] s [3] = '{16'd100, 16'd300, 16'd200};
        int want [3] = '{100, 300, 300};
        logic [N-2:0] l;
        logic [LEDS-1:0] b;
        do_reset();
        for (int i = 0; i < 3; i++) model_step(s[i], e_level[i], e_bar[i], e_clip[i]);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            valid = 1'b1; sample_data = s[i];
        end
        @(negedge clk);
        valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (level_valid !== 1'b1 || int'(level) !== want[i] || level !== e_level[i] || bar !== e_bar[i])
                $display("FAIL b2b[%0d]: lv=%b level=%0d bar=%h, required lv=1 level=%0d bar=%h",
                         i, level_valid, level, bar, want[i], e_bar[i]);
            else passed++;
            @(negedge clk);
        end
        run_sample(16'h7FFF, "b2b_clip", l, b);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({level, bar, clip, level_valid} !== '0)
            $display("FAIL async_reset: level=%0d bar=%h clip=%b lv=%b, required all 0", level, bar, clip, level_valid);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        run_sample('0, "post_reset", l, b);
    endtask

    function automatic logic [N-1:0] rand_sample();
        int r;
        logic [N-1:0] s;
        r = int'($urandom_range(0, 9));
        if (r < 4) s = '0;
        else if (r < 6) s = N'($urandom_range(1, 300));
        else if (r < 8) s = N'($urandom);
        else if (r == 8) s = 16'h7FFF;
        else s = 16'h8000;
        if (r >= 4 && r < 6 && $urandom_range(0, 1) == 1) s = -s;
        return s;
    endfunction

    task automatic test_random();
        logic [N-2:0] l;
        logic [LEDS-1:0] b;
        logic [N-1:0] s [24];
        logic [N-2:0] e_level [24];
        logic [LEDS-1:0] e_bar [24];
        logic e_clip [24];
        for (int i = 0; i < 60; i++) run_sample(rand_sample(), "rand_serial", l, b);
        for (int i = 0; i < 24; i++) begin
            s[i] = rand_sample();
            model_step(s[i], e_level[i], e_bar[i], e_clip[i]);
        end
        fork
            begin
                for (int i = 0; i < 24; i++) begin
                    @(negedge clk);
                    valid = 1'b1; sample_data = s[i];
                end
                @(negedge clk);
                valid = 1'b0;
            end
            begin
                for (int k = 0; k < 24; k++) begin
                    int w;
                    w = 0;
                    @(negedge clk);
                    while (!level_valid && w < 10) begin
                        @(negedge clk);
                        w++;
                    end
                    checks++;
                    if (!level_valid || {level, bar, clip} !== {e_level[k], e_bar[k], e_clip[k]})
                        $display("FAIL rand_stream[%0d]: lv=%b level=%0d bar=%h clip=%b, required level=%0d bar=%h clip=%b",
                                 k, level_valid, level, bar, clip, e_level[k], e_bar[k], e_clip[k]);
                    else passed++;
                end
            end
        join
    endtask

    initial begin
        test_reset();
        test_clip();
        test_decay();
        test_bar();
        test_freeze();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
